// File: rtl/motoro3_phase_sequencer_if.sv
// Bus between a controller and the three-phase commutation sequencer.
// The revCnt signal exists only when MOTORO3_SEQ_REVCNT_EN is defined.
interface motoro3_phase_sequencer_if;
    logic        run;
    logic        dir;
    logic [15:0] stepLen;
    logic [3:0]  deadLen;
    logic [2:0]  mosEnable;
    logic [2:0]  h1_L0;
    logic [2:0]  step;
    logic        stepPulse;
    logic        busy;
`ifdef MOTORO3_SEQ_REVCNT_EN
    logic [15:0] revCnt;
`endif

    modport master (
        output run, dir, stepLen, deadLen,
        input  mosEnable, h1_L0, step, stepPulse, busy
`ifdef MOTORO3_SEQ_REVCNT_EN
        , input revCnt
`endif
    );

    modport slave (
        input  run, dir, stepLen, deadLen,
        output mosEnable, h1_L0, step, stepPulse, busy
`ifdef MOTORO3_SEQ_REVCNT_EN
        , output revCnt
`endif
    );
endinterface

// File: rtl/motoro3_phase_sequencer.sv
// Six-step BLDC commutation sequencer: IDLE -> DEAD -> DRIVE -> DEAD ...
// All state updates on the falling clk edge; nRst is asynchronous, active low.
// Optional feature: define MOTORO3_SEQ_REVCNT_EN to add the saturating revCnt output.
module motoro3_phase_sequencer (
    input logic                      clk,
    input logic                      nRst,
    motoro3_phase_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDead, StDrive} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [2:0]  mos_q, mos_d;
    logic [2:0]  h1_q, h1_d;
    logic        pulse_q, pulse_d;
    logic [15:0] dead_len, drive_len;
    logic [2:0]  step_next;
`ifdef MOTORO3_SEQ_REVCNT_EN
    logic [15:0] rev_q, rev_d;
    logic        wrap;
`endif

    // Phase driven to the high side for a step (bit0 = A, bit1 = B, bit2 = C).
    function automatic logic [2:0] high_sel(input logic [2:0] s);
        case (s)
            3'd0, 3'd1: high_sel = 3'b001;
            3'd2, 3'd3: high_sel = 3'b010;
            3'd4, 3'd5: high_sel = 3'b100;
            default:    high_sel = 3'b000;
        endcase
    endfunction

    // Phase driven to the low side for a step.
    function automatic logic [2:0] low_sel(input logic [2:0] s);
        case (s)
            3'd0, 3'd5: low_sel = 3'b010;
            3'd1, 3'd2: low_sel = 3'b100;
            3'd3, 3'd4: low_sel = 3'b001;
            default:    low_sel = 3'b000;
        endcase
    endfunction

    // Zero-length intervals are stretched to a single cycle.
    assign dead_len  = (bus.deadLen == 4'd0) ? 16'd1 : {12'd0, bus.deadLen};
    assign drive_len = (bus.stepLen == 16'd0) ? 16'd1 : bus.stepLen;

    // Modulo-6 step advance in the requested direction.
    always_comb begin
        if (bus.dir) begin
            step_next = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        end else begin
            step_next = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
        end
    end

`ifdef MOTORO3_SEQ_REVCNT_EN
    assign wrap = bus.dir ? (step_q == 3'd5) : (step_q == 3'd0);
`endif

    // Next-state and registered-output logic; run=0 always wins and stops on the next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        mos_d   = mos_q;
        h1_d    = h1_q;
        pulse_d = 1'b0;
`ifdef MOTORO3_SEQ_REVCNT_EN
        rev_d   = rev_q;
`endif
        case (state_q)
            StIdle: begin
                mos_d = 3'b000;
                h1_d  = 3'b000;
                if (bus.run) begin
                    state_d = StDead;
                    step_d  = 3'd0;
                    h1_d    = high_sel(3'd0);
                    cnt_d   = dead_len;
`ifdef MOTORO3_SEQ_REVCNT_EN
                    rev_d   = 16'd0;
`endif
                end
            end
            StDead: begin
                if (!bus.run) begin
                    state_d = StIdle;
                    mos_d   = 3'b000;
                    h1_d    = 3'b000;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'd1) begin
                    state_d = StDrive;
                    mos_d   = high_sel(step_q) | low_sel(step_q);
                    cnt_d   = drive_len;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDrive: begin
                if (!bus.run) begin
                    state_d = StIdle;
                    mos_d   = 3'b000;
                    h1_d    = 3'b000;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'd1) begin
                    // Side select is only reloaded on the edge that drops all enables.
                    state_d = StDead;
                    step_d  = step_next;
                    pulse_d = 1'b1;
                    mos_d   = 3'b000;
                    h1_d    = high_sel(step_next);
                    cnt_d   = dead_len;
`ifdef MOTORO3_SEQ_REVCNT_EN
                    if (wrap && (rev_q != 16'hFFFF)) begin
                        rev_d = rev_q + 16'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                mos_d   = 3'b000;
                h1_d    = 3'b000;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State register; async reset clears enables without waiting for a clock edge.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            step_q  <= 3'd0;
            mos_q   <= 3'b000;
            h1_q    <= 3'b000;
            pulse_q <= 1'b0;
`ifdef MOTORO3_SEQ_REVCNT_EN
            rev_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            mos_q   <= mos_d;
            h1_q    <= h1_d;
            pulse_q <= pulse_d;
`ifdef MOTORO3_SEQ_REVCNT_EN
            rev_q   <= rev_d;
`endif
        end
    end

    assign bus.mosEnable = mos_q;
    assign bus.h1_L0     = h1_q;
    assign bus.step      = step_q;
    assign bus.stepPulse = pulse_q;
    assign bus.busy      = (state_q != StIdle);
`ifdef MOTORO3_SEQ_REVCNT_EN
    assign bus.revCnt    = rev_q;
`endif
endmodule

// File: tb/tb_motoro3_phase_sequencer.sv
// Bench for motoro3_phase_sequencer: directed scenarios plus random stimulus,
// every output compared each cycle against a timeline model of the commutation rules.
`timescale 1ns/1ps
module tb_motoro3_phase_sequencer;
    logic clk  = 1'b0;
    logic nRst = 1'b1;

    motoro3_phase_sequencer_if bus ();

    motoro3_phase_sequencer dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    // High / low phase index per step (0 = A, 1 = B, 2 = C).
    int hi_ph [6] = '{0, 0, 1, 1, 2, 2};
    int lo_ph [6] = '{1, 2, 2, 0, 0, 1};

    // Model: position within the current step as a cycle index m_t;
    // cycles [0, m_d) are dead time, [m_d, m_d + m_s) are drive.
    bit m_on    = 1'b0;
    int m_t     = 0;
    int m_d     = 1;
    int m_s     = 1;
    int m_step  = 0;
    bit m_pulse = 1'b0;
    int m_rev   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] exp_h1();
        if (!m_on) return 3'b000;
        return 3'(1 << hi_ph[m_step]);
    endfunction

    function automatic logic [2:0] exp_en();
        if (!m_on || m_t < m_d) return 3'b000;
        return 3'(1 << hi_ph[m_step]) | 3'(1 << lo_ph[m_step]);
    endfunction

    task automatic model_edge();
        bit wrap;
        m_pulse = 1'b0;
        if (!m_on) begin
            if (bus.run) begin
                m_on   = 1'b1;
                m_step = 0;
                m_t    = 0;
                m_d    = (bus.deadLen == 0) ? 1 : int'(bus.deadLen);
                m_rev  = 0;
            end
        end else if (!bus.run) begin
            m_on = 1'b0;
        end else begin
            m_t++;
            if (m_t == m_d) begin
                m_s = (bus.stepLen == 0) ? 1 : int'(bus.stepLen);
            end else if (m_t == m_d + m_s) begin
                wrap    = bus.dir ? (m_step == 5) : (m_step == 0);
                m_step  = bus.dir ? (m_step + 1) % 6 : (m_step + 5) % 6;
                m_pulse = 1'b1;
                if (wrap && m_rev < 65535) m_rev++;
                m_t = 0;
                m_d = (bus.deadLen == 0) ? 1 : int'(bus.deadLen);
            end
        end
    endtask

    task automatic compare_all();
        check("mosEnable", bus.mosEnable, exp_en());
        check("h1_L0", bus.h1_L0, exp_h1());
        check("step", bus.step, 32'(m_step));
        check("stepPulse", bus.stepPulse, m_pulse);
        check("busy", bus.busy, m_on);
`ifdef MOTORO3_SEQ_REVCNT_EN
        check("revCnt", bus.revCnt, 32'(m_rev));
`endif
    endtask

    // One falling edge, then compare #1 later; inputs change only between ticks.
    task automatic tick();
        @(negedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    // Reset pulse placed mid-cycle to show enables clear without a clock edge.
    task automatic pulse_reset();
        #10 nRst = 1'b0;
        #1;
        check("rst_async_mos", bus.mosEnable, 3'b000);
        check("rst_step", bus.step, 3'd0);
        check("rst_h1", bus.h1_L0, 3'b000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_pulse", bus.stepPulse, 1'b0);
        m_on = 1'b0; m_t = 0; m_step = 0; m_pulse = 1'b0; m_rev = 0;
        #20 nRst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int seq[$];
        bit found;

        bus.run = 1'b0; bus.dir = 1'b1; bus.stepLen = 16'd10; bus.deadLen = 4'd2;
        #5 nRst = 1'b0;
        #1;
        check("reset_mos", bus.mosEnable, 3'b000);
        check("reset_h1", bus.h1_L0, 3'b000);
        check("reset_step", bus.step, 3'd0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_pulse", bus.stepPulse, 1'b0);
        @(negedge clk); #1;
        nRst = 1'b1;

        // Forward run: stepLen=10, deadLen=2.
        bus.run = 1'b1;
        tick();
        check("enter_dead_busy", bus.busy, 1'b1);
        check("enter_dead_mos", bus.mosEnable, 3'b000);
        last = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.stepPulse) begin
                if (last >= 0) check("pulse_period12", 32'(cyc - last), 32'd12);
                last = cyc;
                seq.push_back(int'(bus.step));
            end
        end
        check("fwd_pulse_count", 32'(seq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < seq.size()) check("fwd_seq", 32'(seq[i]), 32'((i + 1) % 6));
        end

        // Reverse from step 2.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = (m_step == 2);
        end
        check("wait_step2", found, 1'b1);
        bus.dir = 1'b0;
        seq.delete();
        for (int i = 0; i < 80 && seq.size() < 4; i++) begin
            tick();
            if (bus.stepPulse) seq.push_back(int'(bus.step));
        end
        check("rev_pulse_count", 32'(seq.size()), 32'd4);
        if (seq.size() == 4) begin
            check("rev_seq0", 32'(seq[0]), 32'd1);
            check("rev_seq1", 32'(seq[1]), 32'd0);
            check("rev_seq2", 32'(seq[2]), 32'd5);
            check("rev_seq3", 32'(seq[3]), 32'd4);
        end
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = (m_step == 3) && (m_t >= m_d);
        end
        check("wait_step3_drive", found, 1'b1);
        check("step3_mos", bus.mosEnable, 3'b011);
        check("step3_h1", bus.h1_L0, 3'b010);

        // Minimum intervals.
        bus.dir = 1'b1; bus.deadLen = 4'd0; bus.stepLen = 16'd0;
        for (int i = 0; i < 16; i++) tick();
        last = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.stepPulse) begin
                if (last >= 0) check("pulse_period2", 32'(cyc - last), 32'd2);
                last = cyc;
            end
        end

        // Stop on the 5th drive cycle, then restart.
        bus.stepLen = 16'd10; bus.deadLen = 4'd2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = m_on && (m_s == 10) && (m_t == m_d + 4);
        end
        check("wait_drive5", found, 1'b1);
        bus.run = 1'b0;
        tick();
        check("stop_mos", bus.mosEnable, 3'b000);
        check("stop_busy", bus.busy, 1'b0);
        check("stop_no_pulse", bus.stepPulse, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        bus.run = 1'b1;
        tick();
        check("restart_step", bus.step, 3'd0);
        check("restart_dead_mos", bus.mosEnable, 3'b000);
        tick();
        tick();
        check("restart_drive_mos", bus.mosEnable, 3'b011);
        check("restart_drive_h1", bus.h1_L0, 3'b001);

        // Asynchronous reset in the middle of drive.
        tick();
        pulse_reset();
        tick();
        check("post_reset_dead", bus.busy, 1'b1);

`ifdef MOTORO3_SEQ_REVCNT_EN
        bus.run = 1'b0; bus.stepLen = 16'd1; bus.deadLen = 4'd1;
        tick();
        bus.run = 1'b1;
        tick();
        last = 0;
        for (int i = 0; i < 100 && last < 13; i++) begin
            tick();
            if (m_pulse) last++;
        end
        check("rev_13_steps_seen", 32'(last), 32'd13);
        check("revcnt_13", bus.revCnt, 16'd2);
        bus.run = 1'b0;
        tick();
        bus.run = 1'b1;
        tick();
        check("revcnt_restart", bus.revCnt, 16'd0);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 19) == 0) bus.dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) bus.stepLen = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 14) == 0) bus.deadLen = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) pulse_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
